// File: rtl/mem_lane_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_lane_pkg
// Brief  : Shared encodings, lane-rotation/fault helpers and response type.
// Rev    : 1.0
// ============================================================================
package mem_lane_pkg;

  localparam int MAX_LANES = 8;

  localparam logic [MAX_LANES-1:0] BE_BYTE = 8'h01;
  localparam logic [MAX_LANES-1:0] BE_HALF = 8'h03;
  localparam logic [MAX_LANES-1:0] BE_WORD = 8'h0F;

  typedef struct packed {
    logic [8*MAX_LANES-1:0] rdata;
    logic                   fault;
  } resp_t;

  function automatic int unsigned popcount(input logic [MAX_LANES-1:0] be);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_LANES; i++) n += 32'(be[i]);
    return n;
  endfunction

  // True when the access runs past the end of its word into the next one.
  function automatic logic span_fault(input int unsigned off,
                                      input logic [MAX_LANES-1:0] be,
                                      input int unsigned lanes);
    return (off + popcount(be)) > lanes;
  endfunction

  function automatic int unsigned lane_rot(input int unsigned off,
                                           input int unsigned i,
                                           input int unsigned lanes);
    return (off + i) & (lanes - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_unit_if.sv
`default_nettype none
// ============================================================================
// Module : mem_lane_unit_if
// Brief  : Request/response handshake bundle of the lane memory unit.
// Rev    : 1.0
// ============================================================================
interface mem_lane_unit_if #(
  parameter int LANES  = 4,
  parameter int ADDR_W = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_store;
  logic [LANES-1:0]     req_byte_en;
  logic                 req_signed;
  logic [ADDR_W-1:0]    req_addr;
  logic [8*LANES-1:0]   req_wdata;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [8*LANES-1:0]   resp_rdata;
  logic                 resp_fault;

  modport master (
    output req_valid, req_store, req_byte_en, req_signed, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_store, req_byte_en, req_signed, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface
`default_nettype wire

// File: rtl/mem_lane_bank.sv
`default_nettype none
// ============================================================================
// Module : mem_lane_bank
// Brief  : Byte-wide RAM bank, sync read/write port, sync snoop, flat export.
// Rev    : 1.0
// ============================================================================
module mem_lane_bank #(
  parameter int DEPTH       = 16384,
  parameter int SNOOP_WORDS = 8
) (
  input  wire logic                       clk,
  input  wire logic                       resetn,
  input  wire logic                       we,
  input  wire logic                       re,
  input  wire logic [$clog2(DEPTH)-1:0]   addr,
  input  wire logic [7:0]                 wdata,
  output logic      [7:0]                 rdata,
  input  wire logic [$clog2(DEPTH)-1:0]   snoop_addr,
  output logic      [7:0]                 snoop_data,
  output logic      [8*SNOOP_WORDS-1:0]   flat
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;
  logic [7:0] r_snoop;

  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= wdata;
  end

  // Read register only loads on a read, so it holds through response stalls.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rdata <= 8'h00;
      r_snoop <= 8'h00;
    end else begin
      if (re) r_rdata <= r_mem[addr];
      r_snoop <= r_mem[snoop_addr];
    end
  end

  assign rdata      = r_rdata;
  assign snoop_data = r_snoop;

  for (genvar w = 0; w < SNOOP_WORDS; w++) begin : g_flat
    assign flat[8*w +: 8] = r_mem[w];
  end

endmodule
`default_nettype wire

// File: rtl/mem_lane_unit.sv
`default_nettype none
// ============================================================================
// Module : mem_lane_unit
// Brief  : Byte-lane data memory, any-alignment access, valid/ready handshake.
// Rev    : 1.0
// ============================================================================
module mem_lane_unit
  import mem_lane_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int DEPTH_WORDS = 16384,
  parameter int ADDR_W      = 32,
  parameter int SNOOP_WORDS = 8
) (
  input  wire logic                                clk,
  input  wire logic                                resetn,
  mem_lane_unit_if.slave                           bus,
  input  wire logic [$clog2(DEPTH_WORDS)-1:0]      snoop_addr,
  output logic      [8*LANES-1:0]                  snoop_data,
  output logic      [8*LANES*SNOOP_WORDS-1:0]      snoop_flat
);

  localparam int c_off_w  = $clog2(LANES);
  localparam int c_word_w = $clog2(DEPTH_WORDS);

  logic [c_off_w-1:0]  w_off;
  logic [c_word_w-1:0] w_word;
  logic [7:0]          w_be8;
  logic                w_fault;
  logic                w_accept;

  logic               r_valid;
  logic               r_fault;
  logic               r_signed;
  logic [c_off_w-1:0] r_off;
  logic [LANES-1:0]   r_be;

  logic [7:0] w_lane_rdata [LANES];
  logic [7:0] w_byte;
  logic       w_sign;
  resp_t      w_resp;
  logic       w_unused;

  assign w_off    = bus.req_addr[c_off_w-1:0];
  assign w_word   = bus.req_addr[c_off_w +: c_word_w];
  assign w_be8    = 8'(bus.req_byte_en);
  assign w_fault  = (|bus.req_addr[ADDR_W-1:c_off_w+c_word_w]) |
                    ((w_word == c_word_w'(DEPTH_WORDS-1)) &
                     span_fault(32'(w_off), w_be8, 32'(LANES)));

  assign bus.req_ready = ~r_valid | bus.resp_ready;
  assign w_accept      = resetn & bus.req_valid & bus.req_ready;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    localparam logic [c_off_w-1:0] c_j = c_off_w'(j);
    logic [c_off_w-1:0]       w_idx;
    logic [c_word_w-1:0]      w_addr;
    logic                     w_we;
    logic [8*SNOOP_WORDS-1:0] w_flat;

    // Request byte feeding this lane; lanes below the offset sit in the next word.
    assign w_idx  = c_off_w'(lane_rot(32'(LANES) - 32'(w_off), 32'(j), 32'(LANES)));
    assign w_addr = w_word + {{(c_word_w-1){1'b0}}, (c_j < w_off)};
    assign w_we   = w_accept & bus.req_store & ~w_fault & bus.req_byte_en[w_idx];

    mem_lane_bank #(
      .DEPTH       (DEPTH_WORDS),
      .SNOOP_WORDS (SNOOP_WORDS)
    ) u_bank (
      .clk        (clk),
      .resetn     (resetn),
      .we         (w_we),
      .re         (w_accept & ~bus.req_store),
      .addr       (w_addr),
      .wdata      (bus.req_wdata[{w_idx, 3'b000} +: 8]),
      .rdata      (w_lane_rdata[j]),
      .snoop_addr (snoop_addr),
      .snoop_data (snoop_data[8*j +: 8]),
      .flat       (w_flat)
    );

    for (genvar w = 0; w < SNOOP_WORDS; w++) begin : g_export
      assign snoop_flat[8*(w*LANES+j) +: 8] = w_flat[8*w +: 8];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid  <= 1'b0;
      r_fault  <= 1'b0;
      r_signed <= 1'b0;
      r_off    <= '0;
      r_be     <= '0;
    end else if (w_accept) begin
      r_valid <= ~bus.req_store | w_fault;
      if (~bus.req_store | w_fault) begin
        r_fault  <= w_fault;
        r_signed <= bus.req_signed;
        r_off    <= w_off;
        r_be     <= bus.req_byte_en;
      end
    end else if (bus.resp_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Gather bytes back into request order, then extend above the top enabled byte.
  always_comb begin
    w_resp = '0;
    w_byte = 8'h00;
    w_sign = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (r_be[i]) begin
        w_byte = w_lane_rdata[c_off_w'(lane_rot(32'(r_off), 32'(i), 32'(LANES)))];
        w_resp.rdata[8*i +: 8] = w_byte;
        w_sign = r_signed & w_byte[7];
      end
    end
    for (int i = 0; i < LANES; i++) begin
      if (!r_be[i]) w_resp.rdata[8*i +: 8] = {8{w_sign}};
    end
    if (r_fault) w_resp.rdata = '0;
    w_resp.fault = r_fault;
  end

  assign bus.resp_valid = r_valid;
  assign bus.resp_rdata = w_resp.rdata[8*LANES-1:0];
  assign bus.resp_fault = w_resp.fault;
  assign w_unused       = &{1'b0, w_resp};

endmodule
`default_nettype wire

// File: tb/tb_mem_lane_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_lane_unit
// Brief  : Scoreboard bench for mem_lane_unit (LANES=4, DEPTH_WORDS=16384).
// Rev    : 1.0
// ============================================================================
module tb_mem_lane_unit;
  import mem_lane_pkg::*;

  localparam int LANES = 4;
  localparam int DEPTH = 16384;
  localparam int AW    = 32;
  localparam int SW    = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mem_lane_unit_if #(.LANES(LANES), .ADDR_W(AW)) bus ();
  logic [13:0]        snoop_addr;
  logic [31:0]        snoop_data;
  logic [8*LANES*SW-1:0] snoop_flat;

  mem_lane_unit #(
    .LANES(LANES), .DEPTH_WORDS(DEPTH), .ADDR_W(AW), .SNOOP_WORDS(SW)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus),
    .snoop_addr (snoop_addr),
    .snoop_data (snoop_data),
    .snoop_flat (snoop_flat)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [32:0] sb_q[$];
  logic [32:0] mon_exp;
  logic [7:0]  model [4*DEPTH];

  // {fault, rdata} a correct unit returns for this request, from the byte model.
  function automatic logic [32:0] exp_resp(input logic [31:0] addr, input logic [3:0] be,
                                           input logic sgn);
    logic [31:0] r;
    logic        s;
    int          cnt;
    cnt = 0;
    for (int i = 0; i < 4; i++) cnt += 32'(be[i]);
    if (addr[31:16] != 16'h0 || (addr[15:2] == 14'h3FFF && 32'(addr[1:0]) + cnt > 4))
      return {1'b1, 32'h0};
    r = 32'h0;
    s = 1'b0;
    for (int i = 0; i < 4; i++)
      if (be[i]) begin
        r[8*i +: 8] = model[32'(addr[15:0]) + i];
        s = sgn & r[8*i+7];
      end
    for (int i = 0; i < 4; i++)
      if (!be[i]) r[8*i +: 8] = {8{s}};
    return {1'b0, r};
  endfunction

  always @(negedge clk) begin
    if (resetn && bus.resp_valid && bus.resp_ready) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL resp_unexpected: got rdata=%h fault=%b, required no response",
                 bus.resp_rdata, bus.resp_fault);
      end else begin
        mon_exp = sb_q.pop_front();
        if ({bus.resp_fault, bus.resp_rdata} !== mon_exp) begin
          n_fail++;
          $display("FAIL resp: got fault=%b rdata=%h, required fault=%b rdata=%h",
                   bus.resp_fault, bus.resp_rdata, mon_exp[32], mon_exp[31:0]);
        end
      end
    end
  end

  // Drives one request from posedge+1 until accepted; returns at posedge+1.
  task automatic issue(input logic st, input logic [3:0] be, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd);
    int          waited;
    logic        acc;
    logic [32:0] e;
    waited = 0;
    acc = 1'b0;
    bus.req_valid   = 1'b1;
    bus.req_store   = st;
    bus.req_byte_en = be;
    bus.req_signed  = sgn;
    bus.req_addr    = addr;
    bus.req_wdata   = wd;
    while (!acc) begin
      @(negedge clk);
      acc = bus.req_ready;
      @(posedge clk);
      #1;
      if (!acc) begin
        waited++;
        if (waited > 50) begin
          n_tests++;
          n_fail++;
          $display("FAIL issue_timeout: addr=%h not accepted after %0d cycles, required accept",
                   addr, waited);
          break;
        end
      end
    end
    bus.req_valid = 1'b0;
    if (acc) begin
      e = exp_resp(addr, be, sgn);
      if (!st || e[32]) sb_q.push_back(e);
      if (st && !e[32])
        for (int i = 0; i < 4; i++)
          if (be[i]) model[32'(addr[15:0]) + i] = wd[8*i +: 8];
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 50 && sb_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb_q.size());
    end
  endtask

  task automatic test_reset();
    #12;
    n_tests++;
    if ({bus.resp_valid, bus.resp_fault, bus.req_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_ctrl: valid/fault/ready=%b, required 001",
               {bus.resp_valid, bus.resp_fault, bus.req_ready});
    end
    n_tests++;
    if (bus.resp_rdata !== 32'h0 || snoop_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: rdata=%h snoop=%h, required 0 0", bus.resp_rdata, snoop_data);
    end
    @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic test_aligned_word();
    issue(1'b1, 4'hF, 1'b0, 32'h10, 32'hDDCCBBAA);
    issue(1'b0, 4'hF, 1'b0, 32'h10, 32'h0);
    wait_drain();
  endtask

  task automatic test_unaligned();
    issue(1'b1, 4'hF, 1'b0, 32'h0, 32'h44332211);
    issue(1'b1, 4'hF, 1'b0, 32'h4, 32'h88776655);
    issue(1'b0, 4'h3, 1'b0, 32'h3, 32'h0);
    issue(1'b1, 4'h1, 1'b0, 32'h4, 32'h00000086);
    issue(1'b0, 4'h3, 1'b1, 32'h3, 32'h0);
    issue(1'b1, 4'h1, 1'b0, 32'h4, 32'h00000055);
    issue(1'b0, 4'h7, 1'b1, 32'h5, 32'h0);
    issue(1'b0, 4'h3, 1'b1, 32'h3, 32'h0);
    wait_drain();
  endtask

  task automatic test_byte_store();
    snoop_addr = 14'd1;
    issue(1'b1, 4'h1, 1'b0, 32'h6, 32'h0000005A);
    n_tests++;
    if (snoop_data !== 32'h88776655) begin
      n_fail++;
      $display("FAIL snoop_old: got %h, required 88776655", snoop_data);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (snoop_data !== 32'h885A6655) begin
      n_fail++;
      $display("FAIL snoop_new: got %h, required 885a6655", snoop_data);
    end
    n_tests++;
    if (snoop_flat[55:48] !== 8'h5A || snoop_flat[31:0] !== 32'h44332211) begin
      n_fail++;
      $display("FAIL snoop_flat: byte6=%h word0=%h, required 5a 44332211",
               snoop_flat[55:48], snoop_flat[31:0]);
    end
    issue(1'b0, 4'hF, 1'b0, 32'h4, 32'h0);
    wait_drain();
  endtask

  task automatic test_backpressure();
    bus.resp_ready = 1'b0;
    issue(1'b0, 4'hF, 1'b0, 32'h10, 32'h0);
    fork
      begin
        issue(1'b0, 4'hF, 1'b0, 32'h0, 32'h0);
        issue(1'b0, 4'hF, 1'b0, 32'h4, 32'h0);
      end
      begin
        logic [31:0] held;
        @(negedge clk);
        held = bus.resp_rdata;
        n_tests++;
        if (bus.req_ready !== 1'b0 || held !== 32'hDDCCBBAA) begin
          n_fail++;
          $display("FAIL stall_entry: ready=%b rdata=%h, required 0 ddccbbaa", bus.req_ready, held);
        end
        repeat (3) begin
          @(negedge clk);
          n_tests++;
          if (bus.resp_rdata !== held || bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold: rdata=%h valid=%b ready=%b, required %h 1 0",
                     bus.resp_rdata, bus.resp_valid, bus.req_ready, held);
          end
        end
        @(posedge clk);
        #1 bus.resp_ready = 1'b1;
      end
    join
    wait_drain();
  endtask

  task automatic test_back_to_back();
    time t0;
    t0 = $time;
    issue(1'b0, 4'hF, 1'b0, 32'h0, 32'h0);
    issue(1'b0, 4'hF, 1'b0, 32'h4, 32'h0);
    issue(1'b0, 4'h3, 1'b0, 32'h2, 32'h0);
    issue(1'b0, 4'hF, 1'b0, 32'h10, 32'h0);
    n_tests++;
    if ($time - t0 != 40 || sb_q.size() != 1 || bus.resp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_back: cycles=%0d pending=%0d valid=%b, required 4 1 1",
               ($time - t0) / 10, sb_q.size(), bus.resp_valid);
    end
    wait_drain();
  endtask

  task automatic test_fault();
    issue(1'b1, 4'hF, 1'b0, 32'hFFFC, 32'h11223344);
    issue(1'b0, 4'hF, 1'b0, 32'hFFFC, 32'h0);
    issue(1'b0, 4'hF, 1'b0, 32'hFFFE, 32'h0);
    issue(1'b1, 4'hF, 1'b0, 32'hFFFE, 32'hDEADBEEF);
    issue(1'b0, 4'h3, 1'b0, 32'hFFFE, 32'h0);
    issue(1'b0, 4'hF, 1'b0, 32'h0, 32'h0);
    issue(1'b0, 4'h1, 1'b0, 32'h10010, 32'h0);
    issue(1'b1, 4'hF, 1'b0, 32'h10010, 32'h12345678);
    issue(1'b0, 4'hF, 1'b0, 32'h10, 32'h0);
    wait_drain();
  endtask

  task automatic test_reset_mid();
    bus.resp_ready = 1'b0;
    issue(1'b0, 4'hF, 1'b0, 32'h4, 32'h0);
    #2 resetn = 1'b0;
    #1;
    n_tests++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b ready=%b rdata=%h, required 0 1 0",
               bus.resp_valid, bus.req_ready, bus.resp_rdata);
    end
    sb_q.delete();
    @(posedge clk);
    #3;
    resetn = 1'b1;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    issue(1'b0, 4'hF, 1'b0, 32'h10, 32'h0);
    issue(1'b0, 4'hF, 1'b0, 32'h4, 32'h0);
    wait_drain();
  endtask

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_store   = 1'b0;
    bus.req_byte_en = '0;
    bus.req_signed  = 1'b0;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.resp_ready  = 1'b1;
    snoop_addr      = '0;
    test_reset();
    test_aligned_word();
    test_unaligned();
    test_byte_store();
    test_backpressure();
    test_back_to_back();
    test_fault();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
